pipeline_stall_controller: RTL

- Central sequencer for the 5-stage MIPS32 pipeline. Turns the hazard unit's combinational hold/flush requests, the multi-cycle multiply/divide unit (MDU) occupancy and the data-memory ready handshake into per-stage register enables and flushes.
- Sits between the hazard detection logic and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers plus the PC register.
- Owns the only stateful stall logic in the core: FSM, MDU cycle counter and optional stall statistics.

---
 rtl/pipeline_stall_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: central stall/flush sequencer for the 5-stage MIPS32 pipeline.
// Combines hazard-unit hold/flush requests, MDU occupancy and the data-memory
// ready handshake into per-stage register enables and flushes.
// Optional feature macro: STALL_PERF_CNT_EN (stall/flush statistics counters).
module pipeline_stall_controller #(
    parameter int unsigned MDU_LATENCY = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_in,
    input  logic        branch_flush_in,
    input  logic        mdu_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    // Set on the MDU result cycle; masks the still-asserted mdu_start of the
    // same instruction until it has actually left EX, so each mult/div gets
    // exactly one busy episode.
    logic             mdu_retire;
    logic             mdu_retire_nxt;
    logic             mem_stall;
    logic             run_eval;

    assign mem_stall = mem_req && !mem_ready;

    // State, countdown and retire-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            mdu_retire <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mdu_retire <= mdu_retire_nxt;
        end
    end

    // Next-state and enable/flush decode.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        mdu_retire_nxt = mdu_retire;
        run_eval       = 1'b0;
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        ifid_flush     = 1'b0;
        idex_en        = 1'b0;
        idex_flush     = 1'b0;
        exmem_en       = 1'b0;
        exmem_flush    = 1'b0;
        memwb_en       = 1'b0;
        mdu_busy       = 1'b0;
        mdu_done       = 1'b0;

        case (state)
            RUN: begin
                run_eval = 1'b1;
            end
            MDU_BUSY: begin
                // Front end frozen; older instructions keep draining unless memory stalls.
                mdu_busy    = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = !mem_stall;
                if (cnt == '0) begin
                    mdu_done       = 1'b1;
                    exmem_flush    = 1'b0;
                    exmem_en       = 1'b1;
                    mdu_retire_nxt = 1'b1;
                    state_nxt      = mem_stall ? MEM_WAIT : RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Release cycle behaves exactly like RUN with no memory stall.
                if (mem_ready) begin
                    run_eval = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (run_eval) begin
            if (mem_stall) begin
                state_nxt = MEM_WAIT;
            end else begin
                state_nxt      = RUN;
                mdu_retire_nxt = 1'b0;
                if (mdu_start && !mdu_retire) begin
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                    cnt_nxt     = CNT_W'(MDU_LATENCY - 1);
                    state_nxt   = MDU_BUSY;
                end else if (hold_in) begin
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = branch_flush_in;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end
            end
        end

        // Reset quiesces every pipeline register for the cycle it is held.
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b0;
            memwb_en    = 1'b0;
            mdu_busy    = 1'b0;
            mdu_done    = 1'b0;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Saturating stall-cycle and branch-flush statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (ifid_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
